// File: rtl/gpio.sv
// Memory-mapped GPIO peripheral: direction, output data with atomic set/clear,
// synchronised inputs and per-pin rise/fall edge capture with a level interrupt.

module gpio #(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0]  OUT_RESET   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq_out,
    input  logic [31:0]      address_in,
    input  logic             sel_in,
    input  logic             read_in,
    output logic [31:0]      read_value_out,
    input  logic [3:0]       write_mask_in,
    input  logic [31:0]      write_value_in,
    output logic             ready_out
);

    typedef enum logic [2:0] {
        RegOut     = 3'd0,
        RegDir     = 3'd1,
        RegIn      = 3'd2,
        RegRiseEn  = 3'd3,
        RegFallEn  = 3'd4,
        RegPending = 3'd5,
        RegOutSet  = 3'd6,
        RegOutClr  = 3'd7
    } reg_e;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] rise, fall, w1c;
    logic [31:0]      lane_mask;
    logic [WIDTH-1:0] wmask, wbits;
    logic [WIDTH-1:0] rd_bits;
    logic             wr_en;
    reg_e             reg_sel;

    assign reg_sel  = reg_e'(address_in[4:2]);
    assign wr_en    = sel_in && (write_mask_in != 4'b0000);
    assign sync_val = sync_q[SYNC_STAGES-1];

    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < 4; k++) begin
            lane_mask[8*k +: 8] = {8{write_mask_in[k]}};
        end
    end

    assign wmask = lane_mask[WIDTH-1:0];
    assign wbits = write_value_in[WIDTH-1:0] & wmask;

    // Edge detection works on the synchronised value, independent of DIR.
    assign rise = sync_val & ~prev_q & rise_en_q;
    assign fall = ~sync_val & prev_q & fall_en_q;

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (wr_en) begin
            unique case (reg_sel)
                RegOut:     out_d     = (out_q & ~wmask) | wbits;
                RegDir:     dir_d     = (dir_q & ~wmask) | wbits;
                RegIn:      ;
                RegRiseEn:  rise_en_d = (rise_en_q & ~wmask) | wbits;
                RegFallEn:  fall_en_d = (fall_en_q & ~wmask) | wbits;
                RegPending: w1c       = wbits;
                RegOutSet:  out_d     = out_q | wbits;
                RegOutClr:  out_d     = out_q & ~wbits;
            endcase
        end
        // A freshly captured edge wins over a same-cycle clear.
        pending_d = (pending_q & ~w1c) | rise | fall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q     <= OUT_RESET;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pending_q <= '0;
            prev_q    <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pending_q <= pending_d;
            prev_q    <= sync_val;
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        rd_bits = '0;
        unique case (reg_sel)
            RegOut:     rd_bits = out_q;
            RegDir:     rd_bits = dir_q;
            RegIn:      rd_bits = sync_val;
            RegRiseEn:  rd_bits = rise_en_q;
            RegFallEn:  rd_bits = fall_en_q;
            RegPending: rd_bits = pending_q;
            RegOutSet:  rd_bits = '0;
            RegOutClr:  rd_bits = '0;
        endcase
    end

    // Unselected reads return zero so the bus can OR all peripherals together.
    assign read_value_out = sel_in ? 32'(rd_bits) : 32'd0;
    assign ready_out      = sel_in;
    assign gpio_out       = out_q;
    assign gpio_oe        = dir_q;
    assign irq_out        = |pending_q;

    logic unused_bits;
    assign unused_bits = ^{address_in[31:5], address_in[1:0], read_in, write_value_in, lane_mask};

endmodule

// File: tb/tb_gpio.sv
// Bench for gpio: constant-expectation vectors and sequences, plus random traffic
// compared against a register-level reference model.

module tb_gpio;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;
    localparam logic [7:0]  OUT_RST = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq_out;
    logic [31:0] address_in;
    logic        sel_in;
    logic        read_in;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic        ready_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpio #(
        .WIDTH      (W),
        .SYNC_STAGES(S),
        .OUT_RESET  (OUT_RST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .gpio_in       (gpio_in),
        .gpio_out      (gpio_out),
        .gpio_oe       (gpio_oe),
        .irq_out       (irq_out),
        .address_in    (address_in),
        .sel_in        (sel_in),
        .read_in       (read_in),
        .read_value_out(read_value_out),
        .write_mask_in (write_mask_in),
        .write_value_in(write_value_in),
        .ready_out     (ready_out)
    );

    // Reference model: architectural registers plus the history of sampled pins.
    logic [7:0] m_out, m_dir, m_rise, m_fall, m_pend;
    logic [7:0] m_hist[$];   // m_hist[0] = most recent sample

    function automatic logic [31:0] model_read(logic [31:0] a, logic s);
        logic [7:0] v;
        v = 8'h00;
        case (a[4:2])
            3'd0: v = m_out;
            3'd1: v = m_dir;
            3'd2: v = m_hist[S-1];
            3'd3: v = m_rise;
            3'd4: v = m_fall;
            3'd5: v = m_pend;
            default: v = 8'h00;
        endcase
        return s ? {24'h0, v} : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_out  = OUT_RST;
        m_dir  = 8'h00;
        m_rise = 8'h00;
        m_fall = 8'h00;
        m_pend = 8'h00;
        m_hist.delete();
        for (int i = 0; i <= S; i++) m_hist.push_back(8'h00);
    endtask

    // One clock: advance the model from pre-edge state, then compare outputs after the edge.
    task automatic cycle();
        logic [7:0] lm, wb, n_out, n_dir, n_rise, n_fall, n_pend, sv, pv, edges;
        lm     = write_mask_in[0] ? 8'hFF : 8'h00;
        wb     = write_value_in[7:0] & lm;
        n_out  = m_out;
        n_dir  = m_dir;
        n_rise = m_rise;
        n_fall = m_fall;
        sv     = m_hist[S-1];
        pv     = m_hist[S];
        edges  = (sv & ~pv & m_rise) | (~sv & pv & m_fall);
        n_pend = m_pend | edges;
        if (sel_in && write_mask_in != 4'b0) begin
            case (address_in[4:2])
                3'd0: n_out  = (m_out & ~lm) | wb;
                3'd1: n_dir  = (m_dir & ~lm) | wb;
                3'd3: n_rise = (m_rise & ~lm) | wb;
                3'd4: n_fall = (m_fall & ~lm) | wb;
                3'd5: n_pend = (m_pend & ~wb) | edges;
                3'd6: n_out  = m_out | wb;
                3'd7: n_out  = m_out & ~wb;
                default: ;
            endcase
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            m_out  = n_out;
            m_dir  = n_dir;
            m_rise = n_rise;
            m_fall = n_fall;
            m_pend = n_pend;
            m_hist.push_front(gpio_in);
            void'(m_hist.pop_back());
        end
        #1;
        chk("gpio_out", {24'h0, gpio_out}, {24'h0, m_out});
        chk("gpio_oe", {24'h0, gpio_oe}, {24'h0, m_dir});
        chk("irq_out", {31'h0, irq_out}, {31'h0, |m_pend});
        chk("ready_out", {31'h0, ready_out}, {31'h0, sel_in});
        chk("read_value", read_value_out, model_read(address_in, sel_in));
    endtask

    task automatic idle(input int n);
        sel_in        = 1'b0;
        read_in       = 1'b0;
        write_mask_in = 4'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        sel_in         = 1'b1;
        read_in        = 1'b0;
        address_in     = a;
        write_mask_in  = m;
        write_value_in = d;
        cycle();
        sel_in        = 1'b0;
        write_mask_in = 4'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        sel_in        = 1'b1;
        read_in       = 1'b1;
        write_mask_in = 4'b0;
        address_in    = a;
        #1;
        v = read_value_out;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [7:0]  exp_out;
        logic [31:0] rd_addr;
        logic        rd_sel;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;

        vecs[0] = '{32'h00, 4'b0001, 32'hFFFF_FF3C, 8'h3C, 32'h00, 1'b1, 32'h0000_003C};
        vecs[1] = '{32'h18, 4'b1111, 32'h0000_0003, 8'h3F, 32'h18, 1'b1, 32'h0};
        vecs[2] = '{32'h1C, 4'b1111, 32'h0000_0030, 8'h0F, 32'h1C, 1'b1, 32'h0};
        vecs[3] = '{32'h04, 4'b0010, 32'hFFFF_FF5A, 8'h0F, 32'h04, 1'b1, 32'h0};
        vecs[4] = '{32'h04, 4'b0001, 32'h0000_005A, 8'h0F, 32'h04, 1'b1, 32'h0000_005A};
        vecs[5] = '{32'h00, 4'b0000, 32'h0000_00AB, 8'h0F, 32'h00, 1'b0, 32'h0};
        vecs[6] = '{32'h08, 4'b1111, 32'h0000_00FF, 8'h0F, 32'h08, 1'b1, 32'h0};
        vecs[7] = '{32'h00, 4'b1111, 32'h1234_5678, 8'h78, 32'h00, 1'b1, 32'h0000_0078};

        reset          = 1'b1;
        gpio_in        = 8'h00;
        address_in     = 32'h0;
        sel_in         = 1'b0;
        read_in        = 1'b0;
        write_mask_in  = 4'b0;
        write_value_in = 32'h0;
        model_reset();
        #2;
        cycle();
        cycle();
        reset = 1'b0;

        // Reset state.
        chk("rst_gpio_out", {24'h0, gpio_out}, 32'h0000_00A5);
        chk("rst_gpio_oe", {24'h0, gpio_oe}, 32'h0);
        chk("rst_irq", {31'h0, irq_out}, 32'h0);
        peek(32'h00, v);
        chk("rst_read_out", v, 32'h0000_00A5);
        sel_in = 1'b0;
        #1;
        chk("rst_read_unsel", read_value_out, 32'h0);

        // Register write/read vectors.
        for (int i = 0; i < 8; i++) begin
            bus_write(vecs[i].addr, vecs[i].mask, vecs[i].wdata);
            chk($sformatf("vec%0d_out", i), {24'h0, gpio_out}, {24'h0, vecs[i].exp_out});
            sel_in        = vecs[i].rd_sel;
            read_in       = 1'b1;
            address_in    = vecs[i].rd_addr;
            write_mask_in = 4'b0;
            #1;
            chk($sformatf("vec%0d_read", i), read_value_out, vecs[i].exp_rd);
            chk($sformatf("vec%0d_ready", i), {31'h0, ready_out}, {31'h0, vecs[i].rd_sel});
            idle(1);
        end

        // Rising edge latency on pin 0.
        bus_write(32'h0C, 4'b1111, 32'h01);
        sel_in = 1'b1; read_in = 1'b1; address_in = 32'h08; write_mask_in = 4'b0;
        gpio_in[0] = 1'b1;
        cycle();
        chk("rise_in_e1", read_value_out, 32'h0);
        cycle();
        chk("rise_in_e2", read_value_out, 32'h1);
        chk("rise_irq_e2", {31'h0, irq_out}, 32'h0);
        cycle();
        chk("rise_irq_e3", {31'h0, irq_out}, 32'h1);
        bus_write(32'h14, 4'b1111, 32'h01);
        chk("rise_w1c_irq", {31'h0, irq_out}, 32'h0);

        // Falling edge on pin 7 with a W1C landing on the capture cycle.
        bus_write(32'h10, 4'b1111, 32'h80);
        gpio_in[7] = 1'b1;
        idle(4);
        gpio_in[7] = 1'b0;
        idle(2);
        bus_write(32'h14, 4'b0001, 32'h80);
        peek(32'h14, v);
        chk("setwins_pending", v, 32'h80);
        chk("setwins_irq", {31'h0, irq_out}, 32'h1);
        bus_write(32'h14, 4'b0001, 32'h80);
        peek(32'h14, v);
        chk("fall_cleared", v, 32'h0);

        // Edges while disabled are forgotten.
        bus_write(32'h0C, 4'b1111, 32'h00);
        gpio_in[1] = 1'b1; idle(3);
        gpio_in[1] = 1'b0; idle(3);
        gpio_in[1] = 1'b1; idle(4);
        bus_write(32'h0C, 4'b1111, 32'h02);
        idle(4);
        peek(32'h14, v);
        chk("late_en_none", v, 32'h0);
        gpio_in[1] = 1'b0; idle(4);
        gpio_in[1] = 1'b1; idle(2);
        peek(32'h14, v);
        chk("late_en_e2", v, 32'h0);
        idle(1);
        peek(32'h14, v);
        chk("late_en_e3", v, 32'h02);

        // Reset in the middle of an input pulse.
        bus_write(32'h14, 4'b1111, 32'hFF);
        bus_write(32'h0C, 4'b1111, 32'hFF);
        idle(3);
        gpio_in[2] = 1'b1;
        idle(3);
        peek(32'h14, v);
        chk("pre_rst_pending", v, 32'h04);
        gpio_in[3] = 1'b1;
        idle(1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        gpio_in[3] = 1'b0;
        chk("mid_rst_out", {24'h0, gpio_out}, 32'hA5);
        chk("mid_rst_oe", {24'h0, gpio_oe}, 32'h0);
        chk("mid_rst_irq", {31'h0, irq_out}, 32'h0);
        peek(32'h0C, v);
        chk("mid_rst_rise_en", v, 32'h0);
        peek(32'h14, v);
        chk("mid_rst_pending", v, 32'h0);
        idle(6);
        peek(32'h14, v);
        chk("post_rst_pending", v, 32'h0);
        chk("post_rst_irq", {31'h0, irq_out}, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) gpio_in[$urandom_range(0, 7)] ^= 1'b1;
            sel_in         = ($urandom_range(0, 3) != 0);
            read_in        = $urandom_range(0, 1) == 1;
            address_in     = $urandom;
            write_mask_in  = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom);
            write_value_in = $urandom;
            reset          = ($urandom_range(0, 59) == 0);
            cycle();
        end
        reset = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
